// File: rtl/mcse_gpio_responder.sv
// mcse_gpio_responder
// Register-side responder for the MCSE GPIO packet bus. Holds DIR/OUT and the
// interrupt register set, synchronizes the pins, latches interrupts and returns
// registered read data plus a registered interrupt request.
module mcse_gpio_responder #(
  parameter int gpio_N  = 32,
  parameter int gpio_AW = 32,
  parameter int gpio_PW = 2*gpio_AW+40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gpio_reg_access,
  input  logic [gpio_PW-1:0] gpio_reg_packet,
  input  logic [gpio_N-1:0]  gpio_in,
  output logic [gpio_N-1:0]  gpio_out,
  output logic [gpio_N-1:0]  gpio_en,
  output logic [gpio_N-1:0]  gpio_reg_rdata,
  output logic               gpio_reg_rvalid,
  output logic [gpio_N-1:0]  gpio_ilat,
  output logic               gpio_irq
);

  localparam logic [3:0] IDX_DIR     = 4'd0;
  localparam logic [3:0] IDX_IN      = 4'd1;
  localparam logic [3:0] IDX_OUT     = 4'd2;
  localparam logic [3:0] IDX_OUTSET  = 4'd3;
  localparam logic [3:0] IDX_OUTCLR  = 4'd4;
  localparam logic [3:0] IDX_OUTXOR  = 4'd5;
  localparam logic [3:0] IDX_IMASK   = 4'd6;
  localparam logic [3:0] IDX_ITYPE   = 4'd7;
  localparam logic [3:0] IDX_IPOL    = 4'd8;
  localparam logic [3:0] IDX_ILAT    = 4'd9;
  localparam logic [3:0] IDX_ILATCLR = 4'd10;

  // Packet fields
  logic               wr_en;
  logic               rd_en;
  logic [gpio_AW-1:0] pkt_addr;
  logic [gpio_AW-1:0] pkt_wdata;
  logic [3:0]         reg_idx;
  logic [gpio_N-1:0]  wdata;
  logic               unused_pkt;

  // Register state
  logic [gpio_N-1:0] dir_q,   dir_d;
  logic [gpio_N-1:0] out_q,   out_d;
  logic [gpio_N-1:0] imask_q, imask_d;
  logic [gpio_N-1:0] itype_q, itype_d;
  logic [gpio_N-1:0] ipol_q,  ipol_d;
  logic [gpio_N-1:0] ilat_q,  ilat_d;

  // Pin synchronizer and edge-detect history
  logic [gpio_N-1:0] s1_q,   s1_d;
  logic [gpio_N-1:0] s2_q,   s2_d;
  logic [gpio_N-1:0] prev_q, prev_d;

  // Read return and interrupt request
  logic [gpio_N-1:0] rdata_q,  rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              irq_q,    irq_d;

  // Interrupt helpers
  logic [gpio_N-1:0] ilat_set;
  logic [gpio_N-1:0] ilat_clr;
  logic [gpio_N-1:0] rd_mux;

  assign wr_en     = gpio_reg_access &  gpio_reg_packet[0];
  assign rd_en     = gpio_reg_access & ~gpio_reg_packet[0];
  assign pkt_addr  = gpio_reg_packet[gpio_AW+39:40];
  assign pkt_wdata = gpio_reg_packet[gpio_PW-1:gpio_AW+40];
  assign reg_idx   = pkt_addr[5:2];
  assign wdata     = pkt_wdata[gpio_N-1:0];

  // Header bits [39:1], low/high address bits and wdata bits above gpio_N carry no meaning here
  assign unused_pkt = ^gpio_reg_packet;

  // Per-bit interrupt condition: edge or level, polarity selected by IPOL; IMASK does not gate latching
  always_comb begin
    ilat_set = (itype_q  & ((ipol_q & s2_q & ~prev_q) | (~ipol_q & ~s2_q & prev_q)))
             | (~itype_q & ((ipol_q & s2_q)           | (~ipol_q & ~s2_q)));
    ilat_clr = '0;
    if (wr_en && (reg_idx == IDX_ILATCLR)) begin
      ilat_clr = wdata;
    end
  end

  // Read mux; write-only and unmapped indices return zero
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_DIR:   rd_mux = dir_q;
      IDX_IN:    rd_mux = s2_q;
      IDX_OUT:   rd_mux = out_q;
      IDX_IMASK: rd_mux = imask_q;
      IDX_ITYPE: rd_mux = itype_q;
      IDX_IPOL:  rd_mux = ipol_q;
      IDX_ILAT:  rd_mux = ilat_q;
      default:   rd_mux = '0;
    endcase
  end

  // Next-state for the register file, synchronizer, interrupt latch and read return
  always_comb begin
    dir_d    = dir_q;
    out_d    = out_q;
    imask_d  = imask_q;
    itype_d  = itype_q;
    ipol_d   = ipol_q;
    s1_d     = gpio_in;
    s2_d     = s1_q;
    prev_d   = s2_q;
    rdata_d  = rdata_q;
    rvalid_d = rd_en;
    // set wins over a simultaneous clear
    ilat_d   = ilat_set | (ilat_q & ~ilat_clr);
    // irq follows the latch one stage later
    irq_d    = |(ilat_q & ~imask_q);

    if (rd_en) begin
      rdata_d = rd_mux;
    end

    if (wr_en) begin
      case (reg_idx)
        IDX_DIR:    dir_d   = wdata;
        IDX_OUT:    out_d   = wdata;
        IDX_OUTSET: out_d   = out_q | wdata;
        IDX_OUTCLR: out_d   = out_q & ~wdata;
        IDX_OUTXOR: out_d   = out_q ^ wdata;
        IDX_IMASK:  imask_d = wdata;
        IDX_ITYPE:  itype_d = wdata;
        IDX_IPOL:   ipol_d  = wdata;
        default:    ;
      endcase
    end
  end

  // State registers; IMASK comes out of reset fully masked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q    <= '0;
      out_q    <= '0;
      imask_q  <= '1;
      itype_q  <= '0;
      ipol_q   <= '0;
      ilat_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      imask_q  <= imask_d;
      itype_q  <= itype_d;
      ipol_q   <= ipol_d;
      ilat_q   <= ilat_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign gpio_out        = out_q;
  assign gpio_en         = dir_q;
  assign gpio_reg_rdata  = rdata_q;
  assign gpio_reg_rvalid = rvalid_q;
  assign gpio_ilat       = ilat_q;
  assign gpio_irq        = irq_q;

endmodule
